// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data-memory controller
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
    localparam int WORD_W = 32;
    localparam int BE_W = 4;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word RAM, synchronous write, asynchronous read (byte enables under DMEM_BYTE_EN)
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 8192
) (
    input  logic                     clk,
    input  logic                     we,
`ifdef DMEM_BYTE_EN
    input  logic [BE_W-1:0]          be,
`endif
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    // Write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
`ifdef DMEM_BYTE_EN
        for (int b = 0; b < BE_W; b++)
            if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
`else
        if (we) mem[addr] <= wdata;
`endif
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller with multi-cycle loads and stall/valid handshake; DMEM_BYTE_EN adds i_be
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_wen,
    input  logic              i_ren,
`ifdef DMEM_BYTE_EN
    input  logic [BE_W-1:0]   i_be,
`endif
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_read_vd,
    output logic              o_stall,
    output logic              o_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RD_LAT + 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     cur_idx;
    logic [AW-1:0]     ram_addr;
    logic [WORD_W-1:0] ram_rdata;
    logic              mis;
    logic              store;
    logic              we;
    logic              unused_addr;

    assign cur_idx = i_addr[AW+1:2];
    assign mis = |i_addr[1:0];
    assign unused_addr = ^i_addr[31:AW+2];
`ifdef DMEM_BYTE_EN
    assign store = i_wen && |i_be;
`else
    assign store = i_wen;
`endif
    assign we = state == IDLE && store && !mis;
    assign ram_addr = state == IDLE ? cur_idx : idx;
    assign o_stall = (state == IDLE && i_ren && !i_wen) || state == READ;

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
`ifdef DMEM_BYTE_EN
        .be    (i_be),
`endif
        .addr  (ram_addr),
        .wdata (i_wdata),
        .rdata (ram_rdata)
    );

    // Load FSM: accept in IDLE, count out the RAM latency in READ, present data in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            o_rdata <= '0;
            o_read_vd <= 1'b0;
            o_err <= 1'b0;
        end else begin
            o_read_vd <= 1'b0;
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    o_err <= (mis && (i_ren || store)) || (i_ren && i_wen);
                    if (i_ren && !i_wen) begin
                        idx <= cur_idx;
                        cnt <= CW'(RD_LAT - 1);
                        state <= READ;
                    end
                end
                READ: begin
                    if (cnt == '0) begin
                        o_rdata <= ram_rdata;
                        o_read_vd <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl (DEPTH=8192, RD_LAT=2)
module tb_dmem_ctrl;
    logic        clk = 0;
    logic        rst = 0;
    logic [31:0] addr = 0;
    logic [31:0] wdata = 0;
    logic        wen = 0;
    logic        ren = 0;
    logic [3:0]  be = 4'hF;
    logic [31:0] rdata;
    logic        read_vd;
    logic        stall;
    logic        err;
    int          total = 0;
    int          passed = 0;

    dmem_ctrl #(.DEPTH(8192), .RD_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (addr),
        .i_wdata   (wdata),
        .i_wen     (wen),
        .i_ren     (ren),
`ifdef DMEM_BYTE_EN
        .i_be      (be),
`endif
        .o_rdata   (rdata),
        .o_read_vd (read_vd),
        .o_stall   (stall),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic exp_err, input string tag);
        addr = a; wdata = d; wen = 1; ren = 0;
        @(negedge clk);
        check({tag, " stall"}, 32'(stall), 0);
        @(posedge clk); #1;
        wen = 0;
        @(negedge clk);
        check({tag, " err"}, 32'(err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input logic exp_err, input string tag);
        int n = 0;
        int e = 0;
        int k = 0;
        addr = a; ren = 1; wen = 0;
        @(negedge clk);
        while (!read_vd && k < 10) begin
            if (stall) n++;
            if (err) e++;
            k++;
            @(negedge clk);
        end
        check({tag, " vd"}, 32'(read_vd), 1);
        check({tag, " stall cycles"}, n, 3);
        check({tag, " data"}, rdata, exp);
        check({tag, " err"}, e, exp_err ? 1 : 0);
        check({tag, " stall in done"}, 32'(stall), 0);
        @(posedge clk); #1;
        ren = 0;
    endtask

    initial begin
        int v;
        #1 rst = 1;
        #2;
        check("reset rdata", rdata, 0);
        check("reset vd", 32'(read_vd), 0);
        check("reset err", 32'(err), 0);
        check("reset stall", 32'(stall), 0);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;

        store(32'h40, 32'hDEADBEEF, 0, "st 0x40");
        do_load(32'h40, 32'hDEADBEEF, 0, "ld 0x40");

        store(32'h8000_0040, 32'hCAFEF00D, 0, "st wrap hi");
        do_load(32'h40, 32'hCAFEF00D, 0, "ld wrap hi");
        store(32'h0000_8040, 32'h1111_2222, 0, "st wrap depth");
        do_load(32'h40, 32'h1111_2222, 0, "ld wrap depth");

        store(32'h42, 32'hAAAA_AAAA, 1, "st misaligned");
        do_load(32'h40, 32'h1111_2222, 0, "ld after misaligned st");
        do_load(32'h42, 32'h1111_2222, 1, "ld misaligned");

        addr = 32'h10; wdata = 32'h1234; wen = 1; ren = 1;
        @(negedge clk);
        check("conflict stall", 32'(stall), 0);
        @(posedge clk); #1;
        wen = 0; ren = 0;
        @(negedge clk);
        check("conflict err", 32'(err), 1);
        check("conflict vd", 32'(read_vd), 0);
        @(negedge clk);
        check("conflict vd later", 32'(read_vd), 0);
        @(posedge clk); #1;
        do_load(32'h10, 32'h1234, 0, "ld conflict word");

        addr = 32'h40; ren = 1;
        @(posedge clk); #1;
        rst = 1; ren = 0;
        #1;
        check("mid-read rst rdata", rdata, 0);
        check("mid-read rst vd", 32'(read_vd), 0);
        check("mid-read rst stall", 32'(stall), 0);
        check("mid-read rst err", 32'(err), 0);
        @(negedge clk) rst = 0;
        v = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (read_vd) v++;
        end
        check("no vd after rst", v, 0);
        @(posedge clk); #1;
        do_load(32'h10, 32'h1234, 0, "ld after rst");

        do_load(32'h40, 32'h1111_2222, 0, "b2b first");
        do_load(32'h10, 32'h1234, 0, "b2b second");

        addr = 32'h20; wdata = 32'h5A5A_0F0F; wen = 1;
        @(posedge clk); #1;
        wen = 0;
        do_load(32'h20, 32'h5A5A_0F0F, 0, "st then ld");

`ifdef DMEM_BYTE_EN
        store(32'h80, 32'hFFFF_FFFF, 0, "be preload");
        be = 4'b0101;
        store(32'h80, 32'h0000_0000, 0, "be partial");
        be = 4'b0000;
        store(32'h82, 32'h0000_0000, 0, "be zero misaligned");
        be = 4'hF;
        do_load(32'h80, 32'hFF00_FF00, 0, "be load");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller sitting directly downstream of the core's load/store port: it owns the word-addressed data RAM and turns core requests into multi-cycle reads with a stall/valid handshake. It consumes the core's `o_memaddr`/`o_write_data`/`o_write_en`/`o_read_en`, and returns `i_read_data`, `i_read_vd` and `i_exstall`. It replaces the zero-latency behavioural memory model used on the core bench.

## Interface
- `DEPTH`, 8192: RAM size in 32-bit words (power of two).
- `RD_LAT`, 2: RAM read latency in cycles, ≥1.
- `clk`  in  1  clock; everything is sampled on its rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-high.
- `i_addr`  in  32  byte address from the core's `o_memaddr`.
- `i_wdata`  in  32  store data.
- `i_wen`  in  1  store request.
- `i_ren`  in  1  load request; the core holds it, `i_addr`, `i_wen` and `i_wdata` stable while `o_stall`=1.
- `o_rdata`  out  32  load data, registered.
- `o_read_vd`  out  1  load data valid, one-cycle pulse.
- `o_stall`  out  1  stall to the core's `i_exstall`.
- `o_err`  out  1  one-cycle pulse on a misaligned address or a ren+wen conflict.

## Operation
- Word index is `i_addr[log2(DEPTH)+1:2]`. Upper bits are ignored, so out-of-range addresses wrap modulo DEPTH.
- FSM states are IDLE, READ and DONE.
- **IDLE, `i_wen`=1:**
  - Write commits at the end of the cycle. No stall, stay in IDLE.
  - If `i_ren` is also 1, the read is dropped and `o_err` pulses.
- **IDLE, `i_ren`=1, `i_wen`=0:**
  - Latch the word index.
  - Load `cnt`=RD_LAT-1 and go to READ.
- **READ:**
  - Decrement `cnt` each cycle.
  - At `cnt`=0, register `o_rdata`<=RAM[latched index] and go to DONE.
- **DONE:**
  - `o_read_vd`=1 and `o_stall`=0.
  - All request inputs are ignored, because they belong to the load being completed.
  - Return to IDLE.
- **Misaligned address (`i_addr[1:0]`≠0) sampled in IDLE:**
  - `o_err` pulses in the next cycle.
  - A misaligned store is suppressed.
  - A misaligned load proceeds on the aligned word.
- `o_rdata` holds its last value until the next load completes.
- RAM contents are not affected by reset.

## Timing
- `o_stall` = (IDLE & `i_ren` & !`i_wen`) | READ. This is combinational, so it asserts in the same cycle the load appears.
- A load sampled in cycle T:
  - READ occupies cycles T+1 … T+RD_LAT.
  - DONE, with `o_read_vd`=1, is cycle T+RD_LAT+1.
  - `o_stall` is high for RD_LAT+1 cycles (T … T+RD_LAT).
- A store sampled in cycle T is visible to a load sampled in cycle T+1.
- Back-to-back loads: the second load is accepted in the IDLE cycle after DONE.
- Reset (asynchronous, at any point including mid-READ):
  - State returns to IDLE and `cnt`=0.
  - `o_rdata`=0, `o_read_vd`=0, `o_err`=0.
  - `o_stall` is then 0 unless a load is presented.
  - An in-flight load is discarded. No valid pulse follows it.

## Configuration
- `DMEM_BYTE_EN`:
  - **Defined:** adds port `i_be` (in, 4) giving per-byte write enables. Only the enabled bytes of the word are written. `i_be`=0 with `i_wen`=1 is a no-op store, and `o_err` does not pulse for it.
  - **Undefined:** there is no `i_be` port, and every store writes the full 32-bit word.

## Structure
- Package `dmem_pkg`:
  - state enum (IDLE/READ/DONE),
  - `WORD_W`=32,
  - `BE_W`=4.
- Sub-module `dmem_ram`:
  - single-port array with a synchronous write (byte-enabled under `DMEM_BYTE_EN`) and an asynchronous read port.
  - The controller registers the read data and models RD_LAT.
- The FSM, counter, error logic and stall decode live in `dmem_ctrl`.

## Test plan
- Store 0xDEADBEEF to 0x40, then load 0x40 with RD_LAT=2 -> `o_stall` high for 3 cycles, then `o_read_vd`=1 with `o_rdata`=0xDEADBEEF in the 4th cycle.
- Store to 0x8000_0040, then load 0x40 (DEPTH=8192) -> wrap-around, load returns the stored value.
- Store to 0x42 -> `o_err` pulses once, RAM[16] unchanged. A load of 0x42 returns RAM[16] with `o_err`=1.
- `i_ren`=`i_wen`=1 at 0x10 with data 0x1234 -> write performed, no stall, `o_err`=1, no `o_read_vd`.
- Assert `rst` in the cycle after a load is accepted -> all outputs go to 0 immediately, no `o_read_vd` follows. A load issued after reset completes normally.
- With `DMEM_BYTE_EN`: preload 0xFFFFFFFF, store 0x00000000 with `i_be`=4'b0101 -> subsequent load returns 0xFF00FF00.
